// File: rtl/decoder_3x8_seq.sv
// 3-to-8 one-hot decoder that holds each accepted code on Y for HOLD_CYC cycles.
// Back-to-back accepts on the last hold cycle produce a gapless Y stream.
module decoder_3x8_seq #(
    parameter int unsigned HOLD_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [2:0]  In,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  Y,
    output logic        out_valid,
    output logic        busy,
    output logic [15:0] dec_cnt
);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    localparam logic [7:0] HoldLoad = 8'(HOLD_CYC - 1);

    state_e      state_q;
    logic [7:0]  hcnt_q;
    logic        accept;

    // Ready in idle, or on the final hold cycle so the next code follows with no gap.
    assign in_ready = !rst && en && ((state_q == StIdle) ||
                                     ((state_q == StActive) && (hcnt_q == 8'd0)));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            hcnt_q    <= 8'd0;
            Y         <= 8'h00;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            dec_cnt   <= 16'h0000;
        end else if (!en) begin
            state_q   <= StIdle;
            hcnt_q    <= 8'd0;
            Y         <= 8'h00;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (accept) begin
            state_q   <= StActive;
            hcnt_q    <= HoldLoad;
            Y         <= 8'd1 << In;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            dec_cnt   <= dec_cnt + 16'd1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    hcnt_q    <= 8'd0;
                    Y         <= 8'h00;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
                StActive: begin
                    if (hcnt_q != 8'd0) begin
                        hcnt_q <= hcnt_q - 8'd1;
                    end else begin
                        state_q   <= StIdle;
                        Y         <= 8'h00;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    hcnt_q    <= 8'd0;
                    Y         <= 8'h00;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_3x8_seq.sv
// Bench for decoder_3x8_seq: a table of directed vectors on a HOLD_CYC=4 instance,
// plus hand-written sequences on a HOLD_CYC=1 instance (streaming and counter wrap).
module tb_decoder_3x8_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4, en4, iv4, rdy4, ov4, busy4;
    logic [2:0]  in4;
    logic [7:0]  y4;
    logic [15:0] cnt4;

    logic        rst1, en1, iv1, rdy1, ov1, busy1;
    logic [2:0]  in1;
    logic [7:0]  y1;
    logic [15:0] cnt1;

    decoder_3x8_seq #(.HOLD_CYC(4)) dut4 (
        .clk(clk), .rst(rst4), .en(en4), .In(in4), .in_valid(iv4), .in_ready(rdy4),
        .Y(y4), .out_valid(ov4), .busy(busy4), .dec_cnt(cnt4)
    );

    decoder_3x8_seq #(.HOLD_CYC(1)) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .In(in1), .in_valid(iv1), .in_ready(rdy1),
        .Y(y1), .out_valid(ov1), .busy(busy1), .dec_cnt(cnt1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Inputs applied before the edge; rdy is the combinational in_ready seen with
    // those inputs; y/ov/cnt are the registered outputs just after the edge.
    typedef struct {
        logic        rst;
        logic        en;
        logic        iv;
        logic [2:0]  in;
        logic        rdy;
        logic [7:0]  y;
        logic        ov;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic e, input logic v,
                                input logic [2:0] i, input logic rd, input logic [7:0] y,
                                input logic ov, input logic [15:0] c);
        vec_t t;
        t.rst = r; t.en = e; t.iv = v; t.in = i;
        t.rdy = rd; t.y = y; t.ov = ov; t.cnt = c;
        return t;
    endfunction

    initial begin
        logic [7:0] e;

        rst1 = 1'b1; en1 = 1'b1; iv1 = 1'b1; in1 = 3'd0;
        rst4 = 1'b1; en4 = 1'b0; iv4 = 1'b0; in4 = 3'd0;

        // Reset, with en and in_valid asserted: reset wins, no accept
        tbl.push_back(mk(1, 1, 1, 3'd3, 0, 8'h00, 0, 16'd0));
        tbl.push_back(mk(1, 1, 1, 3'd3, 0, 8'h00, 0, 16'd0));
        // Single code 5 held for 4 cycles; In changes and stray valids are ignored
        tbl.push_back(mk(0, 1, 1, 3'd5, 1, 8'h20, 1, 16'd1));
        tbl.push_back(mk(0, 1, 0, 3'd7, 0, 8'h20, 1, 16'd1));
        tbl.push_back(mk(0, 1, 1, 3'd1, 0, 8'h20, 1, 16'd1));
        tbl.push_back(mk(0, 1, 0, 3'd5, 0, 8'h20, 1, 16'd1));
        tbl.push_back(mk(0, 1, 0, 3'd5, 1, 8'h00, 0, 16'd1));
        tbl.push_back(mk(0, 1, 0, 3'd5, 1, 8'h00, 0, 16'd1));
        // Sweep 0..7 with in_valid held: ready only on the first row of each code
        for (int k = 0; k < 8; k++) begin
            e = 8'd1 << k;
            for (int j = 0; j < 4; j++)
                tbl.push_back(mk(0, 1, 1, 3'(k), (j == 0), e, 1, 16'(2 + k)));
        end
        tbl.push_back(mk(0, 1, 0, 3'd0, 1, 8'h00, 0, 16'd9));
        // en dropped in the 2nd hold cycle of code 2
        tbl.push_back(mk(0, 1, 1, 3'd2, 1, 8'h04, 1, 16'd10));
        tbl.push_back(mk(0, 1, 0, 3'd2, 0, 8'h04, 1, 16'd10));
        tbl.push_back(mk(0, 0, 1, 3'd3, 0, 8'h00, 0, 16'd10));
        tbl.push_back(mk(0, 0, 1, 3'd3, 0, 8'h00, 0, 16'd10));
        tbl.push_back(mk(0, 1, 0, 3'd3, 1, 8'h00, 0, 16'd10));
        // rst pulsed during hold of code 7, then a fresh accept
        tbl.push_back(mk(0, 1, 1, 3'd7, 1, 8'h80, 1, 16'd11));
        tbl.push_back(mk(0, 1, 0, 3'd7, 0, 8'h80, 1, 16'd11));
        tbl.push_back(mk(1, 1, 1, 3'd1, 0, 8'h00, 0, 16'd0));
        tbl.push_back(mk(0, 1, 1, 3'd6, 1, 8'h40, 1, 16'd1));
        tbl.push_back(mk(0, 1, 0, 3'd6, 0, 8'h40, 1, 16'd1));
        tbl.push_back(mk(0, 1, 0, 3'd6, 0, 8'h40, 1, 16'd1));
        tbl.push_back(mk(0, 1, 0, 3'd6, 0, 8'h40, 1, 16'd1));
        tbl.push_back(mk(0, 1, 0, 3'd6, 1, 8'h00, 0, 16'd1));

        @(posedge clk);
        #1;
        foreach (tbl[n]) begin
            rst4 = tbl[n].rst; en4 = tbl[n].en; iv4 = tbl[n].iv; in4 = tbl[n].in;
            #1;
            check($sformatf("h4 row%0d in_ready", n), 16'(rdy4), 16'(tbl[n].rdy));
            @(posedge clk);
            #1;
            check($sformatf("h4 row%0d Y", n), 16'(y4), 16'(tbl[n].y));
            check($sformatf("h4 row%0d out_valid", n), 16'(ov4), 16'(tbl[n].ov));
            check($sformatf("h4 row%0d busy", n), 16'(busy4), 16'(tbl[n].ov));
            check($sformatf("h4 row%0d dec_cnt", n), cnt4, tbl[n].cnt);
        end
        iv4 = 1'b0;

        // HOLD_CYC=1: reset state, then one code per cycle
        check("h1 reset in_ready", 16'(rdy1), 16'd0);
        check("h1 reset Y", 16'(y1), 16'h0000);
        check("h1 reset dec_cnt", cnt1, 16'h0000);
        rst1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in1 = 3'(k);
            #1;
            check($sformatf("h1 stream%0d in_ready", k), 16'(rdy1), 16'd1);
            @(posedge clk);
            #1;
            e = 8'd1 << k;
            check($sformatf("h1 stream%0d Y", k), 16'(y1), 16'(e));
            check($sformatf("h1 stream%0d out_valid", k), 16'(ov1), 16'd1);
            check($sformatf("h1 stream%0d dec_cnt", k), cnt1, 16'(k + 1));
        end

        // Run the counter up to FFFF, then one more accept wraps it
        for (int k = 8; k < 65535; k++) begin
            in1 = 3'(k);
            @(posedge clk);
            #1;
        end
        check("h1 cnt at max", cnt1, 16'hFFFF);
        check("h1 Y at max", 16'(y1), 16'h0040);
        in1 = 3'd4;
        @(posedge clk);
        #1;
        check("h1 cnt wrap", cnt1, 16'h0000);
        check("h1 Y after wrap", 16'(y1), 16'h0010);
        iv1 = 1'b0;
        @(posedge clk);
        #1;
        check("h1 idle Y", 16'(y1), 16'h0000);
        check("h1 idle out_valid", 16'(ov1), 16'd0);
        check("h1 idle busy", 16'(busy1), 16'd0);
        check("h1 idle dec_cnt", cnt1, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decoder_3x8_seq.md
DECODER_3X8_SEQ -- requirements
Module: decoder_3x8_seq

Interface
REQ-001 Parameter: HOLD_CYC, default 4, number of cycles each decoded one-hot output is held; legal range 1..255.
REQ-002 Port: clk  input  1  rising-edge clock; all state changes on this edge only.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: en  input  1  block enable; low forces idle and blocks acceptance.
REQ-005 Port: In  input  3  binary code to decode (0..7).
REQ-006 Port: in_valid  input  1  In is valid this cycle.
REQ-007 Port: in_ready  output  1  block can accept a code this cycle (combinational).
REQ-008 Port: Y  output  8  registered one-hot decoded output; all-zero when inactive.
REQ-009 Port: out_valid  output  1  registered; high while Y carries a decoded code.
REQ-010 Port: busy  output  1  registered; high in state ACTIVE.
REQ-011 Port: dec_cnt  output  16  registered count of accepted codes.

Function
REQ-012 FSM states: IDLE, ACTIVE; internal hold counter hcnt, 8 bits.
REQ-013 Accept: the block accepts a code on a rising edge where in_valid && in_ready.
REQ-014 in_ready: en && (state==IDLE || (state==ACTIVE && hcnt==0)).
REQ-015 On accept: Y <= 8'b1 << In, out_valid <= 1, hcnt <= HOLD_CYC-1, state <= ACTIVE, dec_cnt <= dec_cnt+1.
REQ-016 Latency: Y reflects the accepted code one cycle after the accepting edge (visible from the edge, not before).
REQ-017 ACTIVE with hcnt!=0 and en=1: hcnt decrements by 1; Y, out_valid unchanged; in_ready=0.
REQ-018 ACTIVE with hcnt==0 and no accept: state <= IDLE, Y <= 0, out_valid <= 0.
REQ-019 ACTIVE with hcnt==0 and accept: back-to-back; new code loaded per REQ-015 with no zero gap cycle on Y.
REQ-020 Hold: every accepted code is driven on Y for exactly HOLD_CYC consecutive cycles unless aborted.
REQ-021 HOLD_CYC=1: hcnt is always 0 in ACTIVE; one code accepted per cycle when in_valid stays high.
REQ-022 IDLE: Y=0, out_valid=0, busy=0; hcnt holds 0.
REQ-023 en low in any state: no accept; on the next edge state <= IDLE, Y <= 0, out_valid <= 0, hcnt <= 0 (abort).
REQ-024 Y is always all-zero or exactly one bit set; never multi-hot; no tristate output.
REQ-025 dec_cnt wraps 16'hFFFF -> 16'h0000 on accept; no saturation.
REQ-026 busy == (state==ACTIVE) and out_valid == busy at all times.
REQ-027 In is sampled only on an accepting edge; changes at other times have no effect.

Reset
REQ-028 rst high at an edge: state <= IDLE, Y <= 8'h00, out_valid <= 0, busy <= 0, hcnt <= 0, dec_cnt <= 16'h0000.
REQ-029 rst has priority over en and accept; in_ready is 0 while rst is high.
REQ-030 rst asserted mid-hold aborts the hold; after release the block behaves as from power-up.

Verification
REQ-031 HOLD_CYC=4, en=1, In=3'd5 with in_valid for one cycle -> Y=8'h20, out_valid=1 for 4 cycles, then Y=0; dec_cnt=1.
REQ-032 HOLD_CYC=4, in_valid held high, In sweeping 0..7 -> Y steps 01,02,04,...,80, each for 4 cycles with no gap; in_ready high only on the last hold cycle.
REQ-033 HOLD_CYC=1, in_valid high every cycle, In=0..7 -> Y changes every cycle with one-hot match; dec_cnt=8.
REQ-034 en dropped in the 2nd hold cycle of In=3'd2 -> Y=0, out_valid=0 the next cycle; in_ready=0 while en=0.
REQ-035 rst pulsed during hold of In=3'd7 -> all outputs 0 next cycle, dec_cnt=0; next accept decodes normally.
REQ-036 dec_cnt preloaded to 16'hFFFF via 65535 accepts (HOLD_CYC=1), one more accept -> dec_cnt=16'h0000.
